shift_add_mult_ctrl: RTL and testbench
======================================

// Module: shift_add_mult_ctrl
// PURPOSE
//  Sequencing controller for the 8-bit shift-and-add multiplier datapath (REG_A/REG_B/REG_ACC/adder/mux).
//  Accepts two operands over the shared data_in bus via a valid/ready handshake: first beat -> reg A, second beat -> reg B.
//  Runs DATA_WIDTH add/shift iterations, then holds the product {ACC,A} with a result valid/ready handshake.
//  Sits between the operand source and the datapath; it drives only control strobes and never touches data.
// PARAMETERS
//  DATA_WIDTH  8  operand width; equals the number of iterations
//  CNT_WIDTH   4  iteration counter width; must satisfy 2**CNT_WIDTH > DATA_WIDTH-1
// PORTS
//  i_clk        in   1  clock; all state updates on rising edge
//  i_rst_n      in   1  asynchronous active-low reset
//  op_valid     in   1  operand beat present on datapath data_in
//  op_ready     out  1  controller accepts operand beat this cycle
//  res_valid    out  1  product stable on datapath out_ACC_reg (high) / out_A_reg (low)
//  res_ready    in   1  consumer takes product
//  busy         out  1  high in WAIT_B, ITER and DONE
//  A_out        in   1  LSB of reg A from datapath
//  load_A       out  1  to datapath: load reg A from data_in
//  load_B       out  1  to datapath: load reg B from data_in
//  clr_ACC_reg  out  1  to datapath: clear accumulator
//  load_ACC     out  1  to datapath: update accumulator (shift, or add-then-shift)
//  sel_SUM      out  1  to datapath: 1 = accumulator takes SUM path, 0 = shift only
//  shift_A_reg  out  1  to datapath: shift reg A right
//  iter_cnt     out  CNT_WIDTH  current iteration index (debug/verification)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; iter_cnt=0; every output 0 except op_ready, which follows IDLE (1 once i_rst_n is high).
//  States: IDLE, WAIT_B, ITER, DONE; one-hot or binary encoding is free.
//  IDLE:   op_ready=1; load_A = op_valid (combinational); on op_valid -> WAIT_B.
//  WAIT_B: op_ready=1; load_B = clr_ACC_reg = op_valid; on op_valid -> ITER, iter_cnt<=0.
//          op_valid low in WAIT_B: hold indefinitely, no strobes.
//  ITER:   op_ready=0; load_ACC=1; shift_A_reg=1; sel_SUM=A_out (combinational).
//          iter_cnt increments each cycle; when iter_cnt==DATA_WIDTH-1 -> DONE, iter_cnt<=0.
//  DONE:   res_valid=1; all datapath strobes 0, so product is held; on res_ready -> IDLE.
//  Outside ITER, sel_SUM=0 and load_ACC=0; shift_A_reg is never high outside ITER.
//  Exactly DATA_WIDTH ITER cycles per operation; never more, never fewer.
//  Latency: B handshake in cycle t -> res_valid first high in cycle t+DATA_WIDTH+1.
//  Throughput: next A beat is accepted no earlier than the cycle after the res handshake (no overlap).
//  op_valid during ITER/DONE is ignored (op_ready=0); the source must hold data until accepted.
//  res_ready while not in DONE: ignored. res_ready in the same cycle res_valid rises: completes, -> IDLE next edge.
//  All handshakes complete only when valid & ready are both sampled high at the rising edge.
//  Reset mid-operation: immediate return to IDLE; datapath contents are undefined and are not reported.
//  No X on any output after reset; A_out is used only in ITER.
// TESTING
//  A=13, B=11 back-to-back beats -> 8 ITER cycles; res_valid in DONE with ACC=0x00, A=0x8F (143).
//  A=0xFF, B=0xFF -> sel_SUM=1 all 8 ITER cycles; product ACC=0xFE, A=0x01 (65025).
//  A=0x00, B=0x5A -> sel_SUM=0 all ITER cycles; product 0x0000; latency exactly 9 cycles after B.
//  op_valid low 3 cycles between A and B beats -> no load_B/clr_ACC_reg in gap; result still correct.
//  res_ready low 5 cycles in DONE -> res_valid held, no strobes, op_ready=0; then 1 cycle -> IDLE.
//  i_rst_n pulsed low at iter_cnt=4 -> all outputs 0 asynchronously, IDLE; new op 3*5 -> product 15.

Source files
------------

// File: rtl/shift_add_mult_ctrl.sv
// -----------------------------------------------------------------------------
// shift_add_mult_ctrl
//   Sequencing controller for an 8-bit shift-and-add multiplier datapath
//   (REG_A / REG_B / REG_ACC / adder / mux). Two operand beats arrive on the
//   datapath's shared data_in bus through a valid/ready handshake: the first
//   beat goes to reg A and the second to reg B. The controller then runs
//   DATA_WIDTH add/shift iterations and holds the product {ACC,A} behind a
//   result valid/ready handshake. It only drives control strobes and never
//   touches data.
//
// Ports
//   i_clk        in   clock, rising edge
//   i_rst_n      in   asynchronous active-low reset
//   op_valid     in   operand beat present on datapath data_in
//   op_ready     out  operand beat accepted this cycle (IDLE / WAIT_B)
//   res_valid    out  product stable in the datapath {ACC,A}
//   res_ready    in   consumer takes the product
//   busy         out  high in WAIT_B, ITER and DONE
//   A_out        in   LSB of reg A from the datapath
//   load_A       out  load reg A from data_in
//   load_B       out  load reg B from data_in
//   clr_ACC_reg  out  clear accumulator
//   load_ACC     out  update accumulator (shift, or add-then-shift)
//   sel_SUM      out  1 = accumulator takes SUM path, 0 = shift only
//   shift_A_reg  out  shift reg A right
//   iter_cnt     out  current iteration index
// -----------------------------------------------------------------------------
module shift_add_mult_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 op_valid,
   output logic                 op_ready,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic                 busy,
   input  logic                 A_out,
   output logic                 load_A,
   output logic                 load_B,
   output logic                 clr_ACC_reg,
   output logic                 load_ACC,
   output logic                 sel_SUM,
   output logic                 shift_A_reg,
   output logic [CNT_WIDTH-1:0] iter_cnt
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT_B = 2'd1,
      S_ITER   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);

   state_t               r_state;
   state_t               w_state_next;
   logic [CNT_WIDTH-1:0] r_iter_cnt;
   logic [CNT_WIDTH-1:0] w_iter_cnt_next;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_iter_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_iter_cnt <= w_iter_cnt_next;
      end
   end

   // Outputs are decoded from the state but additionally qualified by
   // i_rst_n, so every strobe (and op_ready) is low while reset is asserted
   // even though the state register already reads IDLE.
   always_comb begin
      w_state_next    = r_state;
      w_iter_cnt_next = r_iter_cnt;
      op_ready        = 1'b0;
      res_valid       = 1'b0;
      busy            = 1'b0;
      load_A          = 1'b0;
      load_B          = 1'b0;
      clr_ACC_reg     = 1'b0;
      load_ACC        = 1'b0;
      sel_SUM         = 1'b0;
      shift_A_reg     = 1'b0;

      if (i_rst_n) begin
         case (r_state)
            S_IDLE: begin
               op_ready = 1'b1;
               load_A   = op_valid;
               if (op_valid) begin
                  w_state_next = S_WAIT_B;
               end
            end
            S_WAIT_B: begin
               op_ready    = 1'b1;
               busy        = 1'b1;
               load_B      = op_valid;
               clr_ACC_reg = op_valid;
               if (op_valid) begin
                  w_state_next    = S_ITER;
                  w_iter_cnt_next = '0;
               end
            end
            S_ITER: begin
               busy        = 1'b1;
               load_ACC    = 1'b1;
               shift_A_reg = 1'b1;
               // Multiplier LSB selects add-then-shift vs. plain shift.
               sel_SUM     = A_out;
               if (r_iter_cnt == LAST_ITER) begin
                  w_state_next    = S_DONE;
                  w_iter_cnt_next = '0;
               end else begin
                  w_iter_cnt_next = r_iter_cnt + 1'b1;
               end
            end
            S_DONE: begin
               busy      = 1'b1;
               res_valid = 1'b1;
               if (res_ready) begin
                  w_state_next = S_IDLE;
               end
            end
            default: begin
               w_state_next    = S_IDLE;
               w_iter_cnt_next = '0;
            end
         endcase
      end
   end

   assign iter_cnt = r_iter_cnt;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
module tb_shift_add_mult_ctrl;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic       op_valid;
   logic       op_ready;
   logic       res_valid;
   logic       res_ready;
   logic       busy;
   logic       A_out;
   logic       load_A;
   logic       load_B;
   logic       clr_ACC_reg;
   logic       load_ACC;
   logic       sel_SUM;
   logic       shift_A_reg;
   logic [3:0] iter_cnt;

   // small behavioural datapath, driven only by the controller strobes
   logic [7:0]  din;
   logic [7:0]  m_a, m_b, m_acc;
   logic [16:0] m_sum_cat;
   logic [15:0] m_shift_cat;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   always #5 i_clk = ~i_clk;

   shift_add_mult_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .busy        (busy),
      .A_out       (A_out),
      .load_A      (load_A),
      .load_B      (load_B),
      .clr_ACC_reg (clr_ACC_reg),
      .load_ACC    (load_ACC),
      .sel_SUM     (sel_SUM),
      .shift_A_reg (shift_A_reg),
      .iter_cnt    (iter_cnt)
   );

   assign A_out = m_a[0];

   always_comb begin
      m_sum_cat   = {({1'b0, m_acc} + {1'b0, m_b}), m_a};
      m_shift_cat = {m_acc, m_a};
   end

   always @(posedge i_clk) begin
      if (load_A)      m_a   <= din;
      if (load_B)      m_b   <= din;
      if (clr_ACC_reg) m_acc <= 8'h00;
      if (load_ACC) begin
         if (sel_SUM) {m_acc, m_a} <= m_sum_cat[16:1];
         else         {m_acc, m_a} <= {1'b0, m_shift_cat[15:1]};
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         miss_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // all outputs low (used under reset)
   task automatic chk_all_zero(input string tag);
      chk({tag, "_strobes"},
          32'({op_ready, res_valid, busy, load_A, load_B, clr_ACC_reg,
               load_ACC, sel_SUM, shift_A_reg}), 32'd0);
      chk({tag, "_iter_cnt"}, 32'(iter_cnt), 32'd0);
   endtask

   // One full operation, entered at a negedge with the controller in IDLE.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int gap,
                         input int hold, input bit early_rdy, input logic [15:0] exp_prod,
                         input int exp_sum_cnt, input bit chk_sum_cnt);
      int cycles;
      int sum_cnt;
      cycles  = 0;
      sum_cnt = 0;
      // A beat
      din = a; op_valid = 1'b1; res_ready = 1'b0;
      #1;
      chk("idle_op_ready", 32'(op_ready), 32'd1);
      chk("idle_load_A",   32'(load_A),   32'd1);
      chk("idle_busy",     32'(busy),     32'd0);
      @(negedge i_clk);
      // optional idle gap between beats
      op_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         #1;
         chk("gap_no_loadB_clr", 32'({load_B, clr_ACC_reg}), 32'd0);
         chk("gap_ready_busy",   32'({op_ready, busy}),      32'd3);
         @(negedge i_clk);
      end
      // B beat
      din = b; op_valid = 1'b1;
      #1;
      chk("waitb_loadB_clr", 32'({load_B, clr_ACC_reg}), 32'd3);
      chk("waitb_no_loadA",  32'(load_A), 32'd0);
      @(negedge i_clk);
      op_valid  = early_rdy;   // ignored during ITER
      res_ready = early_rdy;   // ignored during ITER
      din = 8'hA5;
      // iterations
      for (int k = 0; k < 20; k++) begin
         #1;
         if (res_valid === 1'b1) break;
         chk("iter_cnt", 32'(iter_cnt), 32'(cycles));
         chk("iter_strobes", 32'({op_ready, load_ACC, shift_A_reg, load_A, load_B}), 32'b01100);
         chk("iter_sel_sum", 32'(sel_SUM), 32'(A_out));
         if (sel_SUM === 1'b1) sum_cnt++;
         cycles++;
         @(negedge i_clk);
      end
      chk("iter_cycles", 32'(cycles), 32'd8);
      if (chk_sum_cnt) chk("sum_count", 32'(sum_cnt), 32'(exp_sum_cnt));
      // DONE, consumer not ready
      for (int h = 0; h < hold; h++) begin
         res_ready = 1'b0; op_valid = 1'b1;
         #1;
         chk("done_hold_valid", 32'({res_valid, busy, op_ready}), 32'b110);
         chk("done_hold_strobes",
             32'({load_A, load_B, clr_ACC_reg, load_ACC, sel_SUM, shift_A_reg}), 32'd0);
         @(negedge i_clk);
      end
      res_ready = 1'b1; op_valid = 1'b0;
      #1;
      chk("done_res_valid", 32'(res_valid), 32'd1);
      chk("product", 32'({m_acc, m_a}), 32'(exp_prod));
      @(negedge i_clk);
      res_ready = 1'b0;
      #1;
      chk("back_to_idle", 32'({op_ready, res_valid, busy}), 32'b100);
      @(negedge i_clk);
   endtask

   initial begin
      i_rst_n = 1'b0; op_valid = 1'b1; res_ready = 1'b0; din = 8'h00;
      #2;
      chk_all_zero("reset");
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1; op_valid = 1'b0;
      #1;
      chk("post_reset_op_ready", 32'(op_ready), 32'd1);
      chk("post_reset_res_valid", 32'(res_valid), 32'd0);
      @(negedge i_clk);

      // 13*11 = 143, consumer ready early
      run_op(8'd13, 8'd11, 0, 0, 1'b1, 16'h008F, 0, 1'b0);
      // 0xFF*0xFF = 0xFE01, adds every iteration
      run_op(8'hFF, 8'hFF, 0, 0, 1'b0, 16'hFE01, 8, 1'b1);
      // 0x00*0x5A = 0, never adds
      run_op(8'h00, 8'h5A, 0, 0, 1'b0, 16'h0000, 0, 1'b1);
      // 3-cycle gap between beats: 7*9 = 63
      run_op(8'd7, 8'd9, 3, 0, 1'b0, 16'd63, 0, 1'b0);
      // consumer stalls 5 cycles: 0x12*0x34 = 0x03A8
      run_op(8'h12, 8'h34, 0, 5, 1'b0, 16'h03A8, 0, 1'b0);

      // reset asserted mid-operation at iter_cnt == 4
      din = 8'h55; op_valid = 1'b1;
      @(negedge i_clk);
      din = 8'h33;
      @(negedge i_clk);
      op_valid = 1'b0;
      for (int k = 0; k < 12; k++) begin
         #1;
         if (iter_cnt === 4'd4) break;
         @(negedge i_clk);
      end
      chk("pre_reset_iter4", 32'({iter_cnt, load_ACC}), 32'({4'd4, 1'b1}));
      i_rst_n = 1'b0; op_valid = 1'b1;
      #1;
      chk_all_zero("midop_reset");
      @(negedge i_clk);
      i_rst_n = 1'b1; op_valid = 1'b0;
      @(negedge i_clk);
      // 3*5 = 15
      run_op(8'd3, 8'd5, 0, 0, 1'b0, 16'd15, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
